// File: rtl/eth_tlp_tap_arb_pkg.sv
// Shared definitions for the TLP tap arbiter: FSM state codes, tag constants
// and the tag-word layout used on the 72-bit capture FIFO write port.
// Word layout is {keep[7:0], data[63:0]}; a tag is the only word with keep == 0.
package eth_tlptap_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TAG  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [7:0] TAG_MAGIC = 8'hA5;
  localparam logic [7:0] TAG_KEEP  = 8'h00;

  typedef struct packed {
    logic [7:0]  keep;
    logic [7:0]  magic;
    logic [6:0]  pad;
    logic        src;
    logic [15:0] seq;
    logic [31:0] ts;
  } tag_word_t;

  function automatic logic [71:0] pack_tag(input logic src, input logic [15:0] seq,
                                           input logic [31:0] ts);
    tag_word_t t;
    t.keep  = TAG_KEEP;
    t.magic = TAG_MAGIC;
    t.pad   = 7'b0;
    t.src   = src;
    t.seq   = seq;
    t.ts    = ts;
    return t;
  endfunction

endpackage

// File: rtl/eth_tlp_tap_arb.sv
// Packet-granular round-robin arbiter sharing one capture FIFO write port
// between two AXI-Stream taps; each packet is preceded by one tag word.
// Latency: grant in IDLE cycle N, tag write N+1, first beat N+2; outputs are
// combinational (no data-path register). Backpressure: full stalls the tag and
// drops the granted tready in the same cycle, so nothing is lost or repeated.
// Ports: clk200/sys_rst (sync, active high); s0_/s1_axis_* tap inputs;
// wr_en/din/full FIFO write side, din = {keep[7:0], data[63:0]}.
module eth_tlp_tap_arb
  import eth_tlptap_pkg::*;
#(
  parameter int TS_W  = 32,
  parameter int SEQ_W = 16
) (
  input  logic        clk200,
  input  logic        sys_rst,
  output logic        s0_axis_tready,
  input  logic        s0_axis_tvalid,
  input  logic [63:0] s0_axis_tdata,
  input  logic [7:0]  s0_axis_tkeep,
  input  logic        s0_axis_tlast,
  output logic        s1_axis_tready,
  input  logic        s1_axis_tvalid,
  input  logic [63:0] s1_axis_tdata,
  input  logic [7:0]  s1_axis_tkeep,
  input  logic        s1_axis_tlast,
  output logic        wr_en,
  output logic [71:0] din,
  input  logic        full
);

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic [SEQ_W-1:0] seq0_q, seq0_d;
  logic [SEQ_W-1:0] seq1_q, seq1_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [SEQ_W-1:0] tag_seq_q, tag_seq_d;
  logic [TS_W-1:0]  tag_ts_q, tag_ts_d;
  logic             grant;
  logic             tag_done;

  // Granted-source mux; only meaningful in DATA.
  logic        sel_vld;
  logic        sel_last;
  logic [63:0] sel_dat;
  logic [7:0]  sel_keep;
  assign sel_vld  = gnt_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last = gnt_q ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_dat  = gnt_q ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_keep = gnt_q ? s1_axis_tkeep  : s0_axis_tkeep;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_gnt_d     = last_gnt_q;
    grant          = 1'b0;
    tag_done       = 1'b0;
    wr_en          = 1'b0;
    din            = '0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          grant   = 1'b1;
          // On a tie the source that did not go last wins.
          gnt_d   = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_gnt_q : s1_axis_tvalid;
          state_d = ST_TAG;
        end
      end
      ST_TAG: begin
        wr_en = !full;
        din   = pack_tag(gnt_q, 16'(tag_seq_q), 32'(tag_ts_q));
        if (!full) begin
          tag_done = 1'b1;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        s0_axis_tready = !gnt_q && !full;
        s1_axis_tready = gnt_q && !full;
        wr_en          = !full && sel_vld;
        din            = {sel_keep, sel_dat};
        if (!full && sel_vld && sel_last) begin
          last_gnt_d = gnt_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag fields are captured at grant so a stalled tag keeps its grant timestamp.
  assign tag_seq_d = grant ? (gnt_d ? seq1_q : seq0_q) : tag_seq_q;
  assign tag_ts_d  = grant ? ts_q : tag_ts_q;

  assign seq0_d = seq0_q + {{(SEQ_W-1){1'b0}}, (tag_done && !gnt_q)};
  assign seq1_d = seq1_q + {{(SEQ_W-1){1'b0}}, (tag_done && gnt_q)};
  assign ts_d   = ts_q + {{(TS_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk200) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      seq0_q     <= '0;
      seq1_q     <= '0;
      ts_q       <= '0;
      tag_seq_q  <= '0;
      tag_ts_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      seq0_q     <= seq0_d;
      seq1_q     <= seq1_d;
      ts_q       <= ts_d;
      tag_seq_q  <= tag_seq_d;
      tag_ts_q   <= tag_ts_d;
    end
  end

endmodule

// File: tb/tb_eth_tlp_tap_arb.sv
// Directed bench for eth_tlp_tap_arb: drives inputs on the falling edge,
// samples outputs shortly after, and logs every FIFO write with its cycle.
module tb_eth_tlp_tap_arb;

  logic        clk200 = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s0_axis_tready, s1_axis_tready;
  logic        s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
  logic [63:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
  logic [7:0]  s0_axis_tkeep = '0, s1_axis_tkeep = '0;
  logic        s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
  logic        wr_en;
  logic [71:0] din;
  logic        full = 1'b0;

  int checks = 0;
  int passed = 0;

  eth_tlp_tap_arb #(.TS_W(32), .SEQ_W(16)) dut (
    .clk200(clk200), .sys_rst(sys_rst),
    .s0_axis_tready(s0_axis_tready), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tready(s1_axis_tready), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast),
    .wr_en(wr_en), .din(din), .full(full)
  );

  always #5 clk200 = ~clk200;

  // Cycle counter: equals the expected timestamp while no forcing is applied.
  logic [31:0] tb_cyc = '0;
  always @(posedge clk200) begin
    if (sys_rst) tb_cyc <= '0;
    else         tb_cyc <= tb_cyc + 32'd1;
  end

  typedef struct { logic [71:0] d; logic [31:0] cyc; } wr_t;
  wr_t wlog[$];
  int  s1_rdy_cnt = 0;
  always begin
    @(negedge clk200);
    #2;
    if (wr_en === 1'b1) wlog.push_back('{d: din, cyc: tb_cyc});
    if (s1_axis_tready === 1'b1) s1_rdy_cnt++;
  end

  task automatic drive_beat(input int src, input logic v, input logic [63:0] d,
                            input logic [7:0] k, input logic l);
    if (src == 0) begin
      s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tkeep = k; s0_axis_tlast = l;
    end else begin
      s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tkeep = k; s1_axis_tlast = l;
    end
  endtask

  function automatic logic rdy(input int src);
    return (src == 0) ? s0_axis_tready : s1_axis_tready;
  endfunction

  // Beats carry data base+i; keep is FF except the last beat, which is 0F.
  task automatic send_pkt(input int src, input int n, input logic [63:0] base);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      drive_beat(src, 1'b1, base + 64'(i), (i == n - 1) ? 8'h0F : 8'hFF, (i == n - 1));
      #1;
      while (rdy(src) !== 1'b1 && t < 100) begin
        @(negedge clk200);
        #1;
        t++;
      end
      checks++;
      if (t >= 100) $display("FAIL send_timeout src=%0d beat=%0d tready=%b want 1", src, i, rdy(src));
      else passed++;
      @(negedge clk200);
    end
    drive_beat(src, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    repeat (3) @(negedge clk200);
    #1;
    checks++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got=%b want=0", wr_en); else passed++;
    checks++; if (din !== 72'h0) $display("FAIL rst_din got=%h want=0", din); else passed++;
    checks++; if (s0_axis_tready !== 1'b0) $display("FAIL rst_s0_rdy got=%b want=0", s0_axis_tready); else passed++;
    checks++; if (s1_axis_tready !== 1'b0) $display("FAIL rst_s1_rdy got=%b want=0", s1_axis_tready); else passed++;
    @(negedge clk200);
    sys_rst = 1'b0;
    @(negedge clk200);
    #1;
    checks++; if (wr_en !== 1'b0) $display("FAIL idle_wr_en got=%b want=0", wr_en); else passed++;
    checks++; if (din !== 72'h0) $display("FAIL idle_din got=%h want=0", din); else passed++;
  endtask

  task automatic test_single;
    int b, r;
    logic [31:0] n;
    @(negedge clk200);
    b = wlog.size();
    r = s1_rdy_cnt;
    n = tb_cyc;
    send_pkt(0, 3, 64'h0123_4567_89AB_CDE0);
    @(negedge clk200);
    checks++; if (wlog.size() != b + 4) $display("FAIL single_count got=%0d want=%0d", wlog.size() - b, 4); else passed++;
    if (wlog.size() >= b + 4) begin
      checks++; if (wlog[b].d !== {8'h00, 8'hA5, 8'h00, 16'h0000, n})
        $display("FAIL single_tag got=%h want=%h", wlog[b].d, {8'h00, 8'hA5, 8'h00, 16'h0000, n}); else passed++;
      checks++; if (wlog[b].cyc !== n + 32'd1) $display("FAIL single_tag_lat got=%0d want=%0d", wlog[b].cyc, n + 32'd1); else passed++;
      checks++; if (wlog[b+1].cyc !== n + 32'd2) $display("FAIL single_beat_lat got=%0d want=%0d", wlog[b+1].cyc, n + 32'd2); else passed++;
      checks++; if (wlog[b+1].d !== 72'hFF_0123_4567_89AB_CDE0) $display("FAIL single_b0 got=%h want=%h", wlog[b+1].d, 72'hFF_0123_4567_89AB_CDE0); else passed++;
      checks++; if (wlog[b+2].d !== 72'hFF_0123_4567_89AB_CDE1) $display("FAIL single_b1 got=%h want=%h", wlog[b+2].d, 72'hFF_0123_4567_89AB_CDE1); else passed++;
      checks++; if (wlog[b+3].d !== 72'h0F_0123_4567_89AB_CDE2) $display("FAIL single_b2 got=%h want=%h", wlog[b+3].d, 72'h0F_0123_4567_89AB_CDE2); else passed++;
    end
    checks++; if (s1_rdy_cnt != r) $display("FAIL single_s1_rdy got=%0d want=0 cycles high", s1_rdy_cnt - r); else passed++;
  endtask

  task automatic test_tie;
    int b;
    logic [7:0]  exp_src [4];
    logic [15:0] exp_seq [4];
    logic [63:0] exp_dat [4];
    exp_src = '{8'h00, 8'h01, 8'h00, 8'h01};
    exp_seq = '{16'd0, 16'd0, 16'd1, 16'd1};
    exp_dat = '{64'hA000, 64'hC000, 64'hB000, 64'hD000};
    @(negedge clk200);
    sys_rst = 1'b1;
    repeat (2) @(negedge clk200);
    sys_rst = 1'b0;
    b = wlog.size();
    fork
      begin send_pkt(0, 2, 64'hA000); send_pkt(0, 2, 64'hB000); end
      begin send_pkt(1, 2, 64'hC000); send_pkt(1, 2, 64'hD000); end
    join
    @(negedge clk200);
    checks++; if (wlog.size() != b + 12) $display("FAIL tie_count got=%0d want=12", wlog.size() - b); else passed++;
    if (wlog.size() >= b + 12) begin
      for (int p = 0; p < 4; p++) begin
        checks++; if (wlog[b+3*p].d[55:48] !== exp_src[p])
          $display("FAIL tie_src%0d got=%h want=%h", p, wlog[b+3*p].d[55:48], exp_src[p]); else passed++;
        checks++; if (wlog[b+3*p].d[47:32] !== exp_seq[p])
          $display("FAIL tie_seq%0d got=%h want=%h", p, wlog[b+3*p].d[47:32], exp_seq[p]); else passed++;
        checks++; if (wlog[b+3*p+1].d !== {8'hFF, exp_dat[p]})
          $display("FAIL tie_beat%0d got=%h want=%h", p, wlog[b+3*p+1].d, {8'hFF, exp_dat[p]}); else passed++;
      end
    end
  endtask

  task automatic test_backpressure;
    int b;
    logic [31:0] n;
    logic [71:0] exp_tag;
    @(negedge clk200);
    b = wlog.size();
    n = tb_cyc;
    exp_tag = {8'h00, 8'hA5, 8'h00, 16'd2, n};
    fork
      send_pkt(0, 3, 64'h3000);
      begin
        for (int c = 0; c < 13; c++) begin
          full = ((c >= 1) && (c <= 5)) || ((c >= 8) && (c <= 10));
          #1;
          if (full) begin
            checks++; if (wr_en !== 1'b0) $display("FAIL bp_wr_en c=%0d got=%b want=0", c, wr_en); else passed++;
            checks++; if (s0_axis_tready !== 1'b0) $display("FAIL bp_rdy c=%0d got=%b want=0", c, s0_axis_tready); else passed++;
          end
          if (c >= 1 && c <= 6) begin
            checks++; if (din !== exp_tag) $display("FAIL bp_tag_hold c=%0d got=%h want=%h", c, din, exp_tag); else passed++;
          end
          @(negedge clk200);
        end
        full = 1'b0;
      end
    join
    @(negedge clk200);
    checks++; if (wlog.size() != b + 4) $display("FAIL bp_count got=%0d want=4", wlog.size() - b); else passed++;
    if (wlog.size() >= b + 4) begin
      checks++; if (wlog[b].cyc !== n + 32'd6) $display("FAIL bp_tag_cyc got=%0d want=%0d", wlog[b].cyc, n + 32'd6); else passed++;
      checks++; if (wlog[b+1].d !== 72'hFF_0000_0000_0000_3000) $display("FAIL bp_b0 got=%h want=%h", wlog[b+1].d, 72'hFF_0000_0000_0000_3000); else passed++;
      checks++; if (wlog[b+2].d !== 72'hFF_0000_0000_0000_3001) $display("FAIL bp_b1 got=%h want=%h", wlog[b+2].d, 72'hFF_0000_0000_0000_3001); else passed++;
      checks++; if (wlog[b+2].cyc !== n + 32'd11) $display("FAIL bp_b1_cyc got=%0d want=%0d", wlog[b+2].cyc, n + 32'd11); else passed++;
      checks++; if (wlog[b+3].d !== 72'h0F_0000_0000_0000_3002) $display("FAIL bp_b2 got=%h want=%h", wlog[b+3].d, 72'h0F_0000_0000_0000_3002); else passed++;
    end
  endtask

  task automatic test_no_preempt;
    int b;
    @(negedge clk200);
    b = wlog.size();
    fork
      send_pkt(0, 4, 64'h5000);
      begin repeat (3) @(negedge clk200); send_pkt(1, 1, 64'h6000); end
    join
    @(negedge clk200);
    checks++; if (wlog.size() != b + 7) $display("FAIL np_count got=%0d want=7", wlog.size() - b); else passed++;
    if (wlog.size() >= b + 7) begin
      checks++; if (wlog[b].d[55:32] !== {8'h00, 16'd3}) $display("FAIL np_s0_tag got=%h want=%h", wlog[b].d[55:32], {8'h00, 16'd3}); else passed++;
      checks++; if (wlog[b+4].d !== 72'h0F_0000_0000_0000_5003) $display("FAIL np_s0_last got=%h want=%h", wlog[b+4].d, 72'h0F_0000_0000_0000_5003); else passed++;
      checks++; if (wlog[b+5].d[71:32] !== {8'h00, 8'hA5, 8'h01, 16'd2}) $display("FAIL np_s1_tag got=%h want=%h", wlog[b+5].d[71:32], {8'h00, 8'hA5, 8'h01, 16'd2}); else passed++;
      checks++; if (wlog[b+5].d[31:0] !== wlog[b+4].cyc + 32'd1) $display("FAIL np_s1_ts got=%0d want=%0d", wlog[b+5].d[31:0], wlog[b+4].cyc + 32'd1); else passed++;
      checks++; if (wlog[b+5].cyc !== wlog[b+4].cyc + 32'd2) $display("FAIL np_s1_cyc got=%0d want=%0d", wlog[b+5].cyc, wlog[b+4].cyc + 32'd2); else passed++;
      checks++; if (wlog[b+6].d !== 72'h0F_0000_0000_0000_6000) $display("FAIL np_s1_beat got=%h want=%h", wlog[b+6].d, 72'h0F_0000_0000_0000_6000); else passed++;
    end
  endtask

  task automatic test_wrap;
    int b;
    @(negedge clk200);
    b = wlog.size();
    force dut.seq0_d = 16'hFFFF;
    force dut.ts_d   = 32'hFFFF_FFFF;
    @(negedge clk200);
    release dut.seq0_d;
    release dut.ts_d;
    send_pkt(0, 1, 64'h7000);
    send_pkt(0, 1, 64'h7100);
    @(negedge clk200);
    checks++; if (wlog.size() != b + 4) $display("FAIL wrap_count got=%0d want=4", wlog.size() - b); else passed++;
    if (wlog.size() >= b + 4) begin
      checks++; if (wlog[b].d !== 72'h00_A5_00_FFFF_FFFF_FFFF) $display("FAIL wrap_tag1 got=%h want=%h", wlog[b].d, 72'h00_A5_00_FFFF_FFFF_FFFF); else passed++;
      checks++; if (wlog[b+2].d !== 72'h00_A5_00_0000_0000_0002) $display("FAIL wrap_tag2 got=%h want=%h", wlog[b+2].d, 72'h00_A5_00_0000_0000_0002); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk200);
    drive_beat(1, 1'b1, 64'h8000, 8'hFF, 1'b0);
    repeat (3) @(negedge clk200);
    drive_beat(1, 1'b1, 64'h8001, 8'hFF, 1'b0);
    sys_rst = 1'b1;
    #1;
    checks++; if (s1_axis_tready !== 1'b1) $display("FAIL rm_beat2_rdy got=%b want=1", s1_axis_tready); else passed++;
    @(negedge clk200);
    sys_rst = 1'b0;
    drive_beat(0, 1'b1, 64'h9000, 8'h0F, 1'b1);
    #1;
    checks++; if (wr_en !== 1'b0) $display("FAIL rm_wr_en got=%b want=0", wr_en); else passed++;
    checks++; if (din !== 72'h0) $display("FAIL rm_din got=%h want=0", din); else passed++;
    checks++; if ({s0_axis_tready, s1_axis_tready} !== 2'b00) $display("FAIL rm_rdy got=%b want=00", {s0_axis_tready, s1_axis_tready}); else passed++;
    @(negedge clk200);
    #1;
    checks++; if (wr_en !== 1'b1) $display("FAIL rm_tag_wr got=%b want=1", wr_en); else passed++;
    checks++; if (din !== 72'h00_A5_00_0000_0000_0000) $display("FAIL rm_tag got=%h want=%h", din, 72'h00_A5_00_0000_0000_0000); else passed++;
    @(negedge clk200);
    drive_beat(0, 1'b0, '0, '0, 1'b0);
    drive_beat(1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_no_preempt();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
